// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared definitions for the FIFO read/write-side arbiters:
//            FSM state encoding, a constant-width clog2 helper and the
//            default configuration constants.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

   localparam int NUM_REQ_DEF    = 4;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int BURST_LEN_DEF  = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // Ceiling log2, evaluated at elaboration time for width calculations.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first set
//            request bit found searching upward from i_prio, wrapping
//            modulo NUM_REQ.
// Ports    : i_req   - request vector
//            i_prio  - index with highest priority this round
//            o_idx   - winning index (0 when nothing requested)
//            o_found - at least one request bit set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IDX_W   = clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_prio,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_found
);

   logic [IDX_W-1:0] w_j;

   // Walk offsets from farthest to nearest so the nearest hit is the last
   // assignment and therefore wins.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      w_j     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_j = IDX_W'((int'(i_prio) + i) % NUM_REQ);
         if (i_req[w_j]) begin
            o_idx   = w_j;
            o_found = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arbiter
// Purpose  : Shares one async-FIFO read port among NUM_REQ consumers.
//            Consumers are granted round-robin in bursts of up to BURST_LEN
//            words; each popped word is returned registered, tagged one-hot
//            with its owner.
// Ports    : r_clk    - read-domain clock
//            r_rst    - asynchronous active-low reset
//            req      - per-consumer level read request
//            rempty   - FIFO empty flag
//            rdata    - FIFO data at current read address (combinational)
//            rinc     - FIFO pop strobe
//            gnt      - registered one-hot grant, zero when idle
//            rd_data  - registered popped word
//            rd_valid - one-hot owner of rd_data, zero when no word
//            busy     - a grant is currently held
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BURST_LEN  = BURST_LEN_DEF
)(
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic                  rempty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  rinc,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [NUM_REQ-1:0]    rd_valid,
   output logic                  busy
);

   localparam int c_IDX_W = clog2(NUM_REQ);
   localparam int c_CNT_W = clog2(BURST_LEN) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(BURST_LEN - 1);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);

   arb_state_t              r_state;
   arb_state_t              w_state_nxt;
   logic [NUM_REQ-1:0]      r_gnt;
   logic [c_IDX_W-1:0]      r_gidx;
   logic [c_IDX_W-1:0]      r_prio;
   logic [c_CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0]   r_rd_data;
   logic [NUM_REQ-1:0]      r_rd_valid;

   logic [c_IDX_W-1:0]      w_win_idx;
   logic                    w_win_found;
   logic [NUM_REQ-1:0]      w_win_oh;
   logic                    w_rinc;
   logic                    w_last;
   logic                    w_exit;
   logic [c_IDX_W-1:0]      w_prio_nxt;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_IDX_W)
   ) u_rr_pick (
      .i_req   (req),
      .i_prio  (r_prio),
      .o_idx   (w_win_idx),
      .o_found (w_win_found)
   );

   assign w_win_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
   assign w_prio_nxt = (r_gidx == c_LAST_IDX) ? '0 : r_gidx + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_rinc      = 1'b0;
      w_last      = 1'b0;
      w_exit      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_win_found && !rempty) begin
               w_state_nxt = BURST;
            end
         end
         BURST: begin
            // Empty gating is done here even if the FIFO controller also
            // blocks pops on empty.
            w_rinc = req[r_gidx] & ~rempty;
            w_last = w_rinc && (r_cnt == c_LAST_CNT);
            w_exit = w_last || !req[r_gidx] || rempty;
            if (w_exit) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_gidx     <= '0;
         r_prio     <= '0;
         r_cnt      <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_valid <= w_rinc ? r_gnt : '0;
         if (w_rinc) begin
            r_rd_data <= rdata;
            r_cnt     <= r_cnt + 1'b1;
         end
         if (r_state == IDLE) begin
            if (w_win_found && !rempty) begin
               r_gnt  <= w_win_oh;
               r_gidx <= w_win_idx;
               r_cnt  <= '0;
            end
         end else if (w_exit) begin
            r_gnt  <= '0;
            r_prio <= w_prio_nxt;
         end
      end
   end

   assign rinc     = w_rinc;
   assign gnt      = r_gnt;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign busy     = (r_state == BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_arbiter
// Purpose  : Self-checking bench for fifo_rd_arbiter. A FIFO model feeds
//            the DUT; a transaction-level arbiter model predicts grants and
//            popped words into a scoreboard that a monitor drains.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

   localparam int NR    = 4;
   localparam int DW    = 8;
   localparam int BL    = 4;
   localparam int DEPTH = 1024;

   typedef struct {
      logic [DW-1:0] data;
      int            owner;
      int            due;
   } exp_t;

   logic          r_clk = 1'b0;
   logic          r_rst = 1'b0;
   logic [NR-1:0] req   = '0;
   logic          rempty;
   logic [DW-1:0] rdata;
   logic          rinc;
   logic [NR-1:0] gnt;
   logic [DW-1:0] rd_data;
   logic [NR-1:0] rd_valid;
   logic          busy;

   logic [DW-1:0] mem [DEPTH];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   bit            auto_fill = 1'b0;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;

   int            m_owner = -1;
   int            m_prio  = 0;
   int            m_cnt   = 0;
   int            m_rd    = 0;
   exp_t          sb_q[$];

   fifo_rd_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .r_clk    (r_clk),
      .r_rst    (r_rst),
      .req      (req),
      .rempty   (rempty),
      .rdata    (rdata),
      .rinc     (rinc),
      .gnt      (gnt),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .busy     (busy)
   );

   always #5 r_clk = ~r_clk;

   // FIFO model: pops follow the DUT's strobe, as a real read controller would.
   assign rempty = (rd_ptr == wr_ptr);
   assign rdata  = mem[rd_ptr % DEPTH];

   always @(posedge r_clk) begin
      if (rinc) rd_ptr <= rd_ptr + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [NR-1:0] onehot(input int idx);
      logic [NR-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   // Reference model: arbitration rules applied per clock edge using the
   // input values seen just before that edge.
   always @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         m_owner = -1;
         m_prio  = 0;
         m_cnt   = 0;
         sb_q.delete();
      end else begin
         bit pop;
         int win;
         cyc++;
         if (m_owner < 0) begin
            win = -1;
            if (!rempty) begin
               for (int k = 0; k < NR; k++) begin
                  if (win < 0 && req[(m_prio + k) % NR]) win = (m_prio + k) % NR;
               end
            end
            if (win >= 0) begin
               m_owner = win;
               m_cnt   = 0;
            end
         end else begin
            pop = req[m_owner] && !rempty;
            if (pop) begin
               sb_q.push_back('{mem[m_rd % DEPTH], m_owner, cyc});
               m_rd++;
               m_cnt++;
            end
            if ((pop && m_cnt == BL) || !req[m_owner] || rempty) begin
               m_prio  = (m_owner + 1) % NR;
               m_owner = -1;
            end
         end
      end
   end

   // Monitor: compares the DUT against the model on the falling edge.
   always @(negedge r_clk) begin
      if (r_rst) begin
         check("gnt",  32'(gnt),  32'(onehot(m_owner)));
         check("busy", 32'(busy), 32'(m_owner >= 0));
         check("rinc", 32'(rinc),
               32'((m_owner >= 0) && req[m_owner] && !rempty));
         if (rd_valid != '0) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word @cyc %0d: got rd_valid %0h, expected none", cyc, rd_valid);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("rd_data",  32'(rd_data),  32'(e.data));
               check("rd_valid", 32'(rd_valid), 32'(onehot(e.owner)));
               check("latency",  32'(cyc),      32'(e.due));
            end
         end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_word @cyc %0d: got no rd_valid, expected word %0h for consumer %0d",
                     cyc, sb_q[0].data, sb_q[0].owner);
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic push_word();
      mem[wr_ptr % DEPTH] = 8'($urandom);
      wr_ptr++;
   endtask

   task automatic cycle();
      @(posedge r_clk);
      #2;
      if (auto_fill && (wr_ptr - rd_ptr) < 8) push_word();
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic wait_gnt(input logic [NR-1:0] mask, input int limit, input string name);
      int i;
      for (i = 0; i < limit; i++) begin
         if ((gnt & mask) != '0) break;
         cycle();
      end
      if (i == limit) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got gnt %0h after %0d cycles, expected a grant in mask %0h", name, gnt, limit, mask);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      r_rst = 1'b0;
      run(2);
      check("rst_gnt",      32'(gnt),      32'h0);
      check("rst_rinc",     32'(rinc),     32'h0);
      check("rst_rd_valid", 32'(rd_valid), 32'h0);
      check("rst_busy",     32'(busy),     32'h0);
      check("rst_rd_data",  32'(rd_data),  32'h0);
      r_rst = 1'b1;
      run(2);

      // Single requester, 6 words: burst of 4, bubble, burst of 2 ending on empty
      repeat (6) push_word();
      req = 4'b0001;
      run(16);
      check("single_all_popped", 32'(rd_ptr), 32'(wr_ptr));
      req = 4'b0000;
      run(3);

      // Round-robin with a never-empty FIFO
      auto_fill = 1'b1;
      run(2);
      req = 4'b1011;
      run(40);
      req = 4'b0000;
      run(4);

      // Early drop: consumer 2 releases after two pops
      req = 4'b0100;
      wait_gnt(4'b0100, 12, "early_drop_grant");
      run(2);
      req = 4'b1001;
      run(12);
      req = 4'b0000;
      run(4);

      // Empty FIFO holds off all grants until a word arrives
      auto_fill = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < 60 && !rempty; i++) cycle();
      run(6);
      check("empty_no_gnt",  32'(gnt),  32'h0);
      check("empty_no_rinc", 32'(rinc), 32'h0);
      push_word();
      run(6);
      req = 4'b0000;
      run(4);

      // Asynchronous reset in the middle of a burst
      auto_fill = 1'b1;
      req = 4'b0001;
      wait_gnt(4'b0001, 12, "reset_burst_grant");
      run(2);
      #1;
      r_rst = 1'b0;
      #1;
      check("async_gnt",      32'(gnt),      32'h0);
      check("async_rinc",     32'(rinc),     32'h0);
      check("async_rd_valid", 32'(rd_valid), 32'h0);
      check("async_busy",     32'(busy),     32'h0);
      run(2);
      r_rst = 1'b1;
      req = 4'b0010;
      wait_gnt(4'b1111, 12, "post_reset_grant");
      check("post_reset_gnt", 32'(gnt), 32'h2);
      run(6);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) auto_fill = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 5) == 0) req = 4'($urandom);
         if (!auto_fill && $urandom_range(0, 2) == 0) push_word();
         cycle();
      end

      // Drain
      auto_fill = 1'b0;
      req = 4'b0000;
      run(8);
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
